// File: rtl/calc_core_param.sv
// Two-operand signed calculator: enter A, enter B, pick an operator, show the result, chain from it.
// The result is registered one cycle after the operator confirm, and sums and products saturate to the RW range.
module calc_core_param #(
    parameter int WIDTH = 4,
    parameter int RW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             confirm,
    input  logic             display_mode_change,
    input  logic [WIDTH-1:0] operand_in,
    input  logic [1:0]       op_sel,
    output logic [RW-1:0]    display_value,
    output logic             display_mode,
    output logic [1:0]       state,
    output logic             result_valid,
    output logic             overflow
);

    localparam int IW = 2 * RW;

    typedef enum logic [1:0] {
        ENTER_A  = 2'b00,
        ENTER_B  = 2'b01,
        ENTER_OP = 2'b10,
        SHOW     = 2'b11
    } state_t;

    state_t               cur_state;
    logic                 confirm_q;
    logic                 mode_chg_q;
    logic                 confirm_arm;
    logic                 mode_chg_arm;
    logic signed [RW-1:0] acc;
    logic signed [RW-1:0] opb;

    logic                 confirm_edge;
    logic                 mode_chg_edge;
    logic signed [RW-1:0] operand_ext;
    logic signed [IW-1:0] a_w;
    logic signed [IW-1:0] b_w;
    logic signed [IW-1:0] res_w;
    logic signed [RW-1:0] res_sat;
    logic                 res_ovf;

    localparam logic signed [IW-1:0] MAX_W = {{(RW + 1){1'b0}}, {(RW - 1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_W = {{(RW + 1){1'b1}}, {(RW - 1){1'b0}}};

    // The arm flags stop a button held through reset release from counting as a press.
    assign confirm_edge  = confirm & ~confirm_q & confirm_arm;
    assign mode_chg_edge = display_mode_change & ~mode_chg_q & mode_chg_arm;
    assign operand_ext   = {{(RW - WIDTH){operand_in[WIDTH-1]}}, operand_in};

    always_comb begin
        a_w     = {{RW{acc[RW-1]}}, acc};
        b_w     = {{RW{opb[RW-1]}}, opb};
        res_w   = '0;
        case (op_sel)
            2'b00:   res_w = a_w + b_w;
            2'b01:   res_w = a_w - b_w;
            2'b10:   res_w = a_w * b_w;
            default: res_w = (a_w > b_w) ? a_w : b_w;
        endcase
        res_ovf = 1'b0;
        res_sat = res_w[RW-1:0];
        if (res_w > MAX_W) begin
            res_ovf = 1'b1;
            res_sat = {1'b0, {(RW - 1){1'b1}}};
        end else if (res_w < MIN_W) begin
            res_ovf = 1'b1;
            res_sat = {1'b1, {(RW - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= ENTER_A;
            acc          <= '0;
            opb          <= '0;
            overflow     <= 1'b0;
            display_mode <= 1'b0;
            confirm_q    <= 1'b0;
            mode_chg_q   <= 1'b0;
            confirm_arm  <= ~confirm;
            mode_chg_arm <= ~display_mode_change;
        end else begin
            confirm_q    <= confirm;
            mode_chg_q   <= display_mode_change;
            confirm_arm  <= confirm_arm | ~confirm;
            mode_chg_arm <= mode_chg_arm | ~display_mode_change;
            if (mode_chg_edge) begin
                display_mode <= ~display_mode;
            end
            if (confirm_edge) begin
                unique case (cur_state)
                    ENTER_A: begin
                        acc       <= operand_ext;
                        overflow  <= 1'b0;
                        cur_state <= ENTER_B;
                    end
                    ENTER_B: begin
                        opb       <= operand_ext;
                        cur_state <= ENTER_OP;
                    end
                    ENTER_OP: begin
                        acc       <= res_sat;
                        overflow  <= res_ovf;
                        cur_state <= SHOW;
                    end
                    SHOW: begin
                        cur_state <= ENTER_B;
                    end
                endcase
            end
        end
    end

    always_comb begin
        display_value = operand_ext;
        case (cur_state)
            ENTER_OP: display_value = opb;
            SHOW:     display_value = acc;
            default:  display_value = operand_ext;
        endcase
    end

    assign state        = cur_state;
    assign result_valid = (cur_state == SHOW);

endmodule

// File: doc/calc_core_param.md
CALC_CORE_PARAM -- requirements
Module: calc_core_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits (signed two's complement, 2..16).
REQ-002 SHALL have parameter RW, default 2*WIDTH, meaning result/accumulator width in bits (RW >= 2*WIDTH).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port confirm  input  1  level button, synchronised and debounced upstream; only its rising edge acts.
REQ-006 SHALL have port display_mode_change  input  1  level button; only its rising edge acts.
REQ-007 SHALL have port operand_in  input  WIDTH  signed operand switches.
REQ-008 SHALL have port op_sel  input  2  operator select: 00 add, 01 sub, 10 mul, 11 max.
REQ-009 SHALL have port display_value  output  RW  signed value for the display driver.
REQ-010 SHALL have port display_mode  output  1  0 decimal, 1 hex.
REQ-011 SHALL have port state  output  2  current FSM state encoding.
REQ-012 SHALL have port result_valid  output  1  high while in SHOW.
REQ-013 SHALL have port overflow  output  1  sticky saturation flag for the current result.

Function
REQ-014 SHALL detect rising edges by registering confirm and display_mode_change; an edge is input high and registered copy low; a held button yields one event.
REQ-015 SHALL implement states ENTER_A=00, ENTER_B=01, ENTER_OP=10, SHOW=11, advancing only on a confirm edge.
REQ-016 ENTER_A: confirm edge SHALL load acc with operand_in sign-extended to RW, clear overflow, go to ENTER_B.
REQ-017 ENTER_B: confirm edge SHALL load opb with operand_in sign-extended to RW, go to ENTER_OP.
REQ-018 ENTER_OP: confirm edge SHALL compute acc op opb per op_sel sampled in that cycle, write the result to acc, go to SHOW; result visible the next cycle (1-cycle latency).
REQ-019 Arithmetic SHALL use an internal width of 2*RW; a result outside the signed RW range SHALL saturate to +2^(RW-1)-1 or -2^(RW-1) and set overflow.
REQ-020 max SHALL return the signed larger of acc and opb; sub SHALL be acc minus opb.
REQ-021 SHOW: confirm edge SHALL chain, keeping acc as operand A, and go to ENTER_B; overflow SHALL clear on the next ENTER_OP commit unless saturation recurs.
REQ-022 display_value SHALL be operand_in sign-extended to RW in ENTER_A and ENTER_B, opb in ENTER_OP, and acc in SHOW; the output is combinational from registered state and the live switches.
REQ-023 A display_mode_change edge SHALL toggle display_mode in any state without affecting FSM, acc, opb or overflow.
REQ-024 Simultaneous confirm and display_mode_change edges SHALL both take effect in the same cycle.
REQ-025 result_valid SHALL equal (state == SHOW).

Reset
REQ-026 While reset is high at a clock edge, state SHALL become ENTER_A and acc, opb, overflow, display_mode and the edge registers SHALL become 0; reset SHALL have priority over all events.
REQ-027 Reset asserted mid-operation, in any state, SHALL discard pending operands, and a confirm held high through reset release SHALL NOT produce an edge.
REQ-028 After reset: display_value = sign-extended operand_in, result_valid = 0, overflow = 0, state = 00.

Verification (WIDTH=4, RW=8)
REQ-029 Confirm with operand_in 7, then -3, then op 00 -> cycle after the third edge: state 11, display_value 4, overflow 0.
REQ-030 Confirm with -8, then -8, then op 10 -> display_value 64, overflow 0; chain with confirm, then 7, then op 10 -> display_value 127, overflow 1.
REQ-031 Hold confirm high for 20 cycles in ENTER_A -> exactly one transition to ENTER_B.
REQ-032 display_mode_change edge coincident with the ENTER_OP confirm, ops 5, 2, 01 -> display_mode 1, display_value 3, state 11.
REQ-033 Reset pulsed in ENTER_OP with acc 5 -> state 00, acc 0, display_mode 0; a following op-11 sequence with -2, -6 -> display_value -2.
